// File: rtl/pwm_update_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_update_ctrl_if
//  Description : Register-side bus of the PWM update sequencer. It carries the
//                commit strobe with its targets, the counter-wrap event, abort,
//                and the active values and status that come back.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_update_ctrl_if #(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 16
);
    logic              cfg_commit;
    logic [WIDTH-1:0]  tgt_period;
    logic [WIDTH-1:0]  tgt_duty1;
    logic [WIDTH-1:0]  tgt_duty2;
    logic [STEP_W-1:0] ramp_step;
    logic              upd_evt;
    logic              abort;
    logic [WIDTH-1:0]  act_period;
    logic [WIDTH-1:0]  act_duty1;
    logic [WIDTH-1:0]  act_duty2;
    logic              busy;
    logic              done;
    logic              clamp;

    // Register block / counter side: drives targets and events, observes status.
    modport master (
        output cfg_commit, tgt_period, tgt_duty1, tgt_duty2, ramp_step,
        output upd_evt, abort,
        input  act_period, act_duty1, act_duty2, busy, done, clamp
    );

    // Sequencer side.
    modport slave (
        input  cfg_commit, tgt_period, tgt_duty1, tgt_duty2, ramp_step,
        input  upd_evt, abort,
        output act_period, act_duty1, act_duty2, busy, done, clamp
    );
endinterface : pwm_update_ctrl_if
`default_nettype wire

// File: rtl/pwm_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_update_ctrl
//  Description : Applies committed period/duty targets of a 2-channel PWM only
//                at counter-wrap boundaries, optionally ramping the duties by a
//                fixed step per PWM period. Duties are always kept <= period.
//  Config      : PWM_UPDCTRL_RAMP_EN - when defined, duty ramping and the RAMP
//                state are built; otherwise every update jumps to the targets.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_update_ctrl #(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pwm_update_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_EVT = 2'd1;
`ifdef PWM_UPDCTRL_RAMP_EN
    localparam logic [1:0] S_RAMP     = 2'd2;
`endif

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_pend_period;
    logic [WIDTH-1:0] r_pend_duty1;
    logic [WIDTH-1:0] r_pend_duty2;
    logic [WIDTH-1:0] r_act_period;
    logic [WIDTH-1:0] r_act_duty1;
    logic [WIDTH-1:0] r_act_duty2;
    logic             r_busy;
    logic             r_done;
    logic             r_clamp;

    // Commit-time limiting of the duties to the committed period.
    logic [WIDTH-1:0] w_commit_duty1;
    logic [WIDTH-1:0] w_commit_duty2;
    logic             w_clamp_hit;

    assign w_commit_duty1 = (bus.tgt_duty1 > bus.tgt_period) ? bus.tgt_period : bus.tgt_duty1;
    assign w_commit_duty2 = (bus.tgt_duty2 > bus.tgt_period) ? bus.tgt_period : bus.tgt_duty2;
    assign w_clamp_hit    = (bus.tgt_duty1 > bus.tgt_period) || (bus.tgt_duty2 > bus.tgt_period);

    // Duty values that an update event would apply from the current pending set.
    logic [WIDTH-1:0] w_next_duty1;
    logic [WIDTH-1:0] w_next_duty2;
    logic             w_targets_met;

`ifdef PWM_UPDCTRL_RAMP_EN
    logic [STEP_W-1:0] r_step;

    // Limit to the new period first, then move toward the target by at most
    // one step. Larger-minus-smaller keeps the arithmetic free of wrap.
    function automatic logic [WIDTH-1:0] f_step_toward(
        input logic [WIDTH-1:0] act,
        input logic [WIDTH-1:0] pend,
        input logic [WIDTH-1:0] period,
        input logic [WIDTH-1:0] step
    );
        logic [WIDTH-1:0] lim;
        logic [WIDTH-1:0] diff;
        lim = (act > period) ? period : act;
        if (step == '0) begin
            return pend;
        end else if (lim < pend) begin
            diff = pend - lim;
            return lim + ((step < diff) ? step : diff);
        end else begin
            diff = lim - pend;
            return lim - ((step < diff) ? step : diff);
        end
    endfunction

    assign w_next_duty1  = f_step_toward(r_act_duty1, r_pend_duty1, r_pend_period, WIDTH'(r_step));
    assign w_next_duty2  = f_step_toward(r_act_duty2, r_pend_duty2, r_pend_period, WIDTH'(r_step));
    assign w_targets_met = (w_next_duty1 == r_pend_duty1) && (w_next_duty2 == r_pend_duty2);

    // Step size captured with each commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step <= '0;
        end else if (bus.abort) begin
            r_step <= '0;
        end else if (bus.cfg_commit) begin
            r_step <= bus.ramp_step;
        end
    end
`else
    // Without ramping the step input has no function.
    logic w_unused_ramp_step;
    assign w_unused_ramp_step = ^bus.ramp_step;

    assign w_next_duty1  = r_pend_duty1;
    assign w_next_duty2  = r_pend_duty2;
    assign w_targets_met = 1'b1;
`endif

    // Sequencer: abort beats everything; an update in WAIT_EVT/RAMP uses the
    // old pending set even when a new commit lands in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pend_period <= '0;
            r_pend_duty1  <= '0;
            r_pend_duty2  <= '0;
            r_act_period  <= '0;
            r_act_duty1   <= '0;
            r_act_duty2   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_clamp       <= 1'b0;
        end else if (bus.abort) begin
            r_state       <= S_IDLE;
            r_pend_period <= '0;
            r_pend_duty1  <= '0;
            r_pend_duty2  <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_clamp       <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_clamp <= 1'b0;

            if (bus.upd_evt && (r_state != S_IDLE)) begin
                r_act_period <= r_pend_period;
                r_act_duty1  <= w_next_duty1;
                r_act_duty2  <= w_next_duty2;
                if (!bus.cfg_commit) begin
                    if (w_targets_met) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
`ifdef PWM_UPDCTRL_RAMP_EN
                    else begin
                        r_state <= S_RAMP;
                        r_busy  <= 1'b1;
                    end
`endif
                end
            end

            if (bus.cfg_commit) begin
                r_pend_period <= bus.tgt_period;
                r_pend_duty1  <= w_commit_duty1;
                r_pend_duty2  <= w_commit_duty2;
                r_clamp       <= w_clamp_hit;
                r_state       <= S_WAIT_EVT;
                r_busy        <= 1'b1;
            end
        end
    end

    assign bus.act_period = r_act_period;
    assign bus.act_duty1  = r_act_duty1;
    assign bus.act_duty2  = r_act_duty2;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.clamp      = r_clamp;

endmodule : pwm_update_ctrl
`default_nettype wire

// File: doc/pwm_update_ctrl.md
# pwm_update_ctrl

Update sequencer for the 2-channel PWM register path. It sits between the I2C-mapped register block and the counter/comparators. It takes software targets for period, duty1 and duty2 and applies them only at counter-wrap boundaries, so no PWM cycle is ever truncated. Duty changes can optionally be ramped in fixed steps, one step per PWM period (soft-start / soft-change).

## Interface
- WIDTH, 32, width of period and duty values
- STEP_W, 16, width of the ramp step size
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_commit  in  1  single-cycle strobe; latches tgt_* and ramp_step
- tgt_period  in  WIDTH  target period (ARR)
- tgt_duty1  in  WIDTH  target channel-1 compare value
- tgt_duty2  in  WIDTH  target channel-2 compare value
- ramp_step  in  STEP_W  duty step per update event; 0 = jump directly
- upd_evt  in  1  single-cycle counter-wrap pulse (CNT wraps on tick)
- abort  in  1  stop sequencing; hold the current active values
- act_period  out  WIDTH  period driven to the counter
- act_duty1  out  WIDTH  duty driven to comparator 1
- act_duty2  out  WIDTH  duty driven to comparator 2
- busy  out  1  a commit is pending or a ramp is in progress
- done  out  1  1-cycle pulse when all act_* equal their pending targets
- clamp  out  1  1-cycle pulse when a committed duty exceeded tgt_period

## Operation
- States:
  - IDLE: nothing pending.
  - WAIT_EVT: commit latched, waiting for a boundary.
  - RAMP: duties still stepping.
- On cfg_commit:
  - pend_period <= tgt_period.
  - pend_dutyN <= min(tgt_dutyN, tgt_period).
  - step <= ramp_step.
  - clamp pulses if either duty was limited.
  - Next state WAIT_EVT.
- On upd_evt in WAIT_EVT or RAMP, apply in this order:
  1. act_period <= pend_period (the period always jumps).
  2. Each act_dutyN is first limited to the new period.
  3. Each act_dutyN then moves toward pend_dutyN by min(step, |pend - act|).
  4. If step == 0, the duties jump to their targets.
- After the update: if all act_* equal their pend_* values, pulse done and go to IDLE; otherwise go to (or stay in) RAMP.
- upd_evt in IDLE: no effect.
- Arithmetic:
  - step is zero-extended to WIDTH.
  - The difference is computed as larger minus smaller, unsigned. No wrap or overflow is possible.
  - Invariant: act_dutyN <= act_period in every cycle.
- cfg_commit while busy:
  - The pending registers are overwritten and the state goes to WAIT_EVT.
  - Ramping resumes from the current act_* values.
- cfg_commit and upd_evt in the same cycle:
  - The event is processed with the old pending values.
  - The new commit is latched.
  - Next state is WAIT_EVT; done is suppressed.
- abort has the highest priority:
  - Go to IDLE; act_* hold; pending is discarded.
  - No done pulse.
  - A cfg_commit in the same cycle is dropped.

## Timing
- Reset (rst high at a clk edge):
  - act_period = act_duty1 = act_duty2 = 0.
  - busy = done = clamp = 0.
  - State IDLE; pending registers and step are 0.
- rst asserted mid-ramp: the next edge restores the reset values. No done pulse.
- All outputs are registered.
- Commit latency:
  - cfg_commit at cycle N → busy = 1 and clamp valid at N+1.
- Update latency:
  - upd_evt at cycle M → act_* updated at M+1.
  - done (if the targets are reached) is high at M+1 only; busy = 0 at M+1.
- Ramp length is ceil(max |ΔdutyN| / step) update events.
- upd_evt is only ever one cycle wide. Back-to-back events are each processed.

## Configuration
- Macro PWM_UPDCTRL_RAMP_EN.
- Defined:
  - Ramp stepping as described above.
  - RAMP state present.
- Undefined:
  - ramp_step is ignored and treated as 0.
  - Every update event jumps all values to their targets.
  - RAMP state and step logic are not generated.
  - The port list is unchanged.

## Test plan
- Reset → all outputs 0, busy 0. A lone upd_evt changes nothing.
- Jump:
  - Stimulus: commit period=1000, duty1=500, duty2=250, step=0; upd_evt 5 cycles later.
  - Response: next cycle act = 1000/500/250, done pulse, busy 0.
- Ramp:
  - Stimulus: from 1000/500/250, commit duty1=100, duty2=400, step=150.
  - Response over successive events:
    - duty1: 350, 200, 100.
    - duty2: 400, 400, 400.
    - done on the 3rd event.
- Clamp and period shrink:
  - Stimulus: from act duty1=500, commit period=300, duty1=400, step=50.
  - Response: clamp pulse (pend duty1=300). First event gives period=300, duty1=300; done.
- Same-cycle events:
  - cfg_commit coincident with upd_evt: old targets applied, busy stays 1, no done. The next event applies the new targets.
- Abort: mid-ramp abort (with a simultaneous commit) → IDLE, act_* frozen, no done. Subsequent upd_evt pulses cause no change.
